// File: rtl/pixel_frame_loader.sv
// Streams 8-bit pixels into a packed frame for the classifier wrapper, pulses start,
// then waits for a done rising edge (or timeout) and reports the predicted digit.
module pixel_frame_loader #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned VECTOR_SIZE    = 196,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             pix_data,
    input  logic                              pix_valid,
    input  logic                              pix_sof,
    output logic                              pix_ready,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] pixels_in,
    output logic                              start,
    input  logic                              done,
    input  logic [3:0]                        predict_digit,
    output logic [3:0]                        digit_out,
    output logic                              digit_valid,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int unsigned FW = DATA_WIDTH * VECTOR_SIZE;
    localparam int unsigned CW = $clog2(VECTOR_SIZE + 1);
    localparam int unsigned SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] FRAME_LAST = CW'(VECTOR_SIZE);
    localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
    localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [FW-1:0]   r_pixels;
    logic [CW-1:0]   r_count;
    logic [SW-1:0]   r_scnt;
    logic [TW-1:0]   r_timer;
    logic            r_done_d;
    logic [3:0]      r_digit;
    logic            r_digit_valid;
    logic            r_timeout_err;

    logic            w_accept;
    logic [CW-1:0]   w_count_inc;
    logic            w_frame_full;
    logic            w_done_rise;
    logic            w_start_end;
    logic            w_timeout;

    assign w_accept     = (r_state == S_LOAD) && pix_valid;
    assign w_count_inc  = pix_sof ? CW'(1) : (r_count + CW'(1));
    assign w_frame_full = w_accept && (w_count_inc == FRAME_LAST);
    assign w_done_rise  = done && !r_done_d;
    assign w_start_end  = (r_state == S_START) && (r_scnt == START_LAST);
    // A done edge on the final timer cycle still counts as completion.
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT) &&
                          !w_done_rise && (r_timer == TIME_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        pix_ready = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                pix_ready = 1'b1;
                if (w_frame_full) w_next = S_START;
            end
            S_START: begin
                start = 1'b1;
                busy  = 1'b1;
                if (w_start_end) w_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_done_rise || w_timeout) w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pixels      <= '0;
            r_count       <= '0;
            r_scnt        <= '0;
            r_timer       <= '0;
            r_done_d      <= 1'b0;
            r_digit       <= '0;
            r_digit_valid <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_d      <= done;
            r_digit_valid <= 1'b0;

            // Partial data before a pix_sof is simply shifted out by the new frame.
            if (w_accept) begin
                r_pixels <= {r_pixels[FW-DATA_WIDTH-1:0], pix_data};
                r_count  <= w_frame_full ? '0 : w_count_inc;
            end
            if (w_frame_full) r_timeout_err <= 1'b0;

            r_scnt  <= ((r_state == S_START) && !w_start_end) ? (r_scnt + SW'(1)) : '0;
            r_timer <= (r_state == S_WAIT) ? (r_timer + TW'(1)) : '0;

            if ((r_state == S_WAIT) && w_done_rise) begin
                r_digit       <= predict_digit;
                r_digit_valid <= 1'b1;
            end
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign pixels_in   = r_pixels;
    assign digit_out   = r_digit;
    assign digit_valid = r_digit_valid;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed bench for pixel_frame_loader: a transaction-level model is compared against
// the DUT on every falling edge, plus literal checks on frame packing and handshake timing.
module tb_pixel_frame_loader;

    localparam int DW = 8;
    localparam int VS = 196;
    localparam int SC = 2;
    localparam int TO = 64;
    localparam int FW = DW * VS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic [FW-1:0] pixels_in;
    logic          start;
    logic          done = 1'b0;
    logic [3:0]    predict_digit = '0;
    logic [3:0]    digit_out;
    logic          digit_valid;
    logic          busy;
    logic          timeout_err;

    always #5 clk = ~clk;

    pixel_frame_loader #(
        .DATA_WIDTH    (DW),
        .VECTOR_SIZE   (VS),
        .START_CYCLES  (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_sof      (pix_sof),
        .pix_ready    (pix_ready),
        .pixels_in    (pixels_in),
        .start        (start),
        .done         (done),
        .predict_digit(predict_digit),
        .digit_out    (digit_out),
        .digit_valid  (digit_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pixels accepted so far (last VS kept), pixels since frame start,
    // cycles of start remaining, and how long we have been waiting for done.
    logic [DW-1:0] m_q[$];
    int            m_cnt = 0;
    int            m_start_left = 0;
    bit            m_wait = 0;
    int            m_age = 0;
    bit            m_done_prev = 0;
    bit            m_dv = 0;
    bit            m_terr = 0;
    logic [3:0]    m_dout = '0;

    function automatic logic [FW-1:0] m_vec();
        logic [FW-1:0] v;
        v = '0;
        foreach (m_q[i]) v = {v[FW-DW-1:0], m_q[i]};
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_cnt = 0; m_start_left = 0; m_wait = 0; m_age = 0;
            m_done_prev = 0; m_dv = 0; m_terr = 0; m_dout = '0;
        end else begin
            m_dv = 0;
            if (m_start_left > 0) begin
                m_start_left--;
                if (m_start_left == 0) begin
                    m_wait = 1;
                    m_age  = 0;
                end
            end else if (m_wait) begin
                if (done && !m_done_prev) begin
                    m_dout = predict_digit;
                    m_dv   = 1;
                    m_wait = 0;
                end else begin
                    m_age++;
                    if (m_age == TO) begin
                        m_terr = 1;
                        m_wait = 0;
                    end
                end
            end else if (pix_valid) begin
                m_q.push_back(pix_data);
                if (m_q.size() > VS) void'(m_q.pop_front());
                m_cnt = pix_sof ? 1 : m_cnt + 1;
                if (m_cnt == VS) begin
                    m_cnt        = 0;
                    m_terr       = 0;
                    m_start_left = SC;
                end
            end
            m_done_prev = done;
        end
    end

    int start_hi = 0;
    int busy_cnt = 0;
    int dv_cnt   = 0;

    always @(negedge clk) begin
        logic [FW-1:0] ev;
        bit            m_busy;
        ev     = m_vec();
        m_busy = (m_start_left > 0) || m_wait;
        chk("pix_ready", 32'(pix_ready), 32'(!m_busy));
        chk("start", 32'(start), 32'(m_start_left > 0));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("digit_valid", 32'(digit_valid), 32'(m_dv));
        chk("digit_out", 32'(digit_out), 32'(m_dout));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        n_vec++;
        if (pixels_in !== ev) begin
            n_err++;
            for (int k = 0; k < VS; k++) begin
                if (pixels_in[FW-1-DW*k -: DW] !== ev[FW-1-DW*k -: DW]) begin
                    $display("FAIL pixels_in: pixel %0d got %h expected %h at %0t",
                             k, pixels_in[FW-1-DW*k -: DW], ev[FW-1-DW*k -: DW], $time);
                    break;
                end
            end
        end
        if (start)       start_hi++;
        if (busy)        busy_cnt++;
        if (digit_valid) dv_cnt++;
    end

    function automatic logic [DW-1:0] pix_val(input int f, input int k);
        int row;
        int col;
        row = k / 14;
        col = k % 14;
        if (f == 1)
            return (((col == 6) || (col == 7)) ? 8'hF0 : 8'h00) | 8'((k + 1) % 16);
        return (((row == 2) || (row == 6) || (row == 11) || (col == 10)) ? 8'hE0 : 8'h00)
               | 8'((k + 3) % 16);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pixel(input logic [DW-1:0] d, input logic sof);
        bit acc;
        int guard;
        acc   = 0;
        guard = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        while (!acc) begin
            acc = pix_ready;
            tick(1);
            guard++;
            if (!acc && guard > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_wait: pix_ready stuck 0, expected 1 within 500 cycles");
                acc = 1;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(input int f, input int n, input bit sof_first, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) tick($urandom_range(1, 3));
            send_pixel(pix_val(f, k), sof_first && (k == 0));
        end
    endtask

    task automatic pulse_done(input logic [3:0] d);
        predict_digit = d;
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    int s0;
    int b0;
    int d0;

    initial begin
        #1 reset = 1'b0;
        tick(3);
        chk("rst_ready", 32'(pix_ready), 32'd1);
        chk("rst_digit", 32'(digit_out), 32'd0);
        reset = 1'b1;
        tick(2);

        // Digit-1 frame, no gaps, done pulse after 50 cycles.
        s0 = start_hi; d0 = dv_cnt;
        send_frame(1, VS, 1, 0);
        tick(50);
        pulse_done(4'd1);
        tick(3);
        chk("s1_start_cycles", 32'(start_hi - s0), 32'd2);
        chk("s1_dv_count", 32'(dv_cnt - d0), 32'd1);
        chk("s1_digit", 32'(digit_out), 32'd1);
        chk("s1_pix0", 32'(pixels_in[FW-1 -: 8]), 32'h01);
        chk("s1_pix195", 32'(pixels_in[7:0]), 32'h04);

        // Gappy frame, then done held as a level across the back-to-back digit-3 frame.
        send_frame(1, VS, 0, 1);
        tick(20);
        predict_digit = 4'd2;
        done = 1'b1;
        tick(3);
        d0 = dv_cnt;
        send_frame(3, VS, 1, 0);
        tick(20);
        chk("s2_level_ignored", 32'(dv_cnt - d0), 32'd0);
        chk("s2_still_busy", 32'(busy), 32'd1);
        done = 1'b0;
        predict_digit = 4'd3;
        tick(1);
        done = 1'b1;
        tick(3);
        chk("s2_dv_count", 32'(dv_cnt - d0), 32'd1);
        chk("s2_digit", 32'(digit_out), 32'd3);
        done = 1'b0;
        tick(2);

        // 100-pixel partial frame abandoned by a new pix_sof.
        s0 = start_hi;
        send_frame(1, 100, 1, 0);
        send_frame(3, VS, 1, 0);
        tick(10);
        chk("s3_one_start", 32'(start_hi - s0), 32'd2);
        chk("s3_pix0", 32'(pixels_in[FW-1 -: 8]), 32'h03);
        chk("s3_pix195", 32'(pixels_in[7:0]), 32'h06);
        pulse_done(4'd7);
        tick(3);
        chk("s3_digit", 32'(digit_out), 32'd7);

        // Timeout with a pixel held valid through START/WAIT.
        b0 = busy_cnt; d0 = dv_cnt;
        send_frame(3, VS, 1, 0);
        send_pixel(8'hAA, 1'b0);
        tick(2);
        chk("s4_busy_cycles", 32'(busy_cnt - b0), 32'(SC + TO));
        chk("s4_timeout", 32'(timeout_err), 32'd1);
        chk("s4_ready", 32'(pix_ready), 32'd1);
        chk("s4_no_dv", 32'(dv_cnt - d0), 32'd0);
        chk("s4_digit_kept", 32'(digit_out), 32'd7);
        send_frame(1, VS, 1, 0);
        tick(5);
        chk("s4_cleared", 32'(timeout_err), 32'd0);
        pulse_done(4'd5);
        tick(3);
        chk("s4_digit", 32'(digit_out), 32'd5);

        // Reset in WAIT, then a done edge that must be ignored.
        d0 = dv_cnt;
        send_frame(1, VS, 1, 0);
        tick(10);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        pulse_done(4'd9);
        tick(3);
        chk("s5_no_dv", 32'(dv_cnt - d0), 32'd0);
        chk("s5_digit", 32'(digit_out), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_ready", 32'(pix_ready), 32'd1);
        chk("s5_pix_top", pixels_in[FW-1 -: 32], 32'd0);
        chk("s5_pix_low", pixels_in[31:0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
